// File: rtl/dsram_responder.sv
// rtl/dsram_responder.sv - data SRAM responder with byte-merge RAM and optional MMIO timer/LED/NUM
//
// Purpose:
//   Answers the core's data SRAM port. Reads return the addressed word one
//   cycle later through a registered rdata. Writes merge byte lanes into a
//   synchronous word RAM. When DSRAM_MMIO_EN is defined, a 64 KB window at
//   MMIO_BASE[31:16] decodes a free-running TIMER (0x0), LED (0x4) and NUM (0x8).
//   Without DSRAM_MMIO_EN every address maps to RAM and led/num are tied to 0.
//
// Parameters:
//   ADDR_W     word-address bits of the RAM (depth 2^ADDR_W words)
//   MMIO_BASE  base of the MMIO window, bits [31:16] compared
//
// Ports:
//   clk              system clock, rising edge
//   rst              synchronous reset, active-low
//   data_sram_en     access request this cycle
//   data_sram_wen    byte write enables (0 with en=1 is a read)
//   data_sram_addr   byte address, bits [1:0] ignored
//   data_sram_wdata  store data, byte-lane aligned
//   data_sram_rdata  registered read data, valid the cycle after the read
//   led              LED register
//   num              NUM register
module dsram_responder #(
   parameter int          ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic [15:0] led,
   output logic [31:0] num
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0]       r_mem [0:DEPTH-1];
   logic [31:0]       r_rdata;
   logic [ADDR_W-1:0] w_idx;
   logic              w_wr;
   logic              w_rd;
   logic [31:0]       w_wmask;
   logic              w_mmio_hit;
   logic [31:0]       w_mmio_rdata;

   // Upper address bits alias the RAM; these bits are intentionally unused.
   logic w_unused;
   assign w_unused = &{1'b0, data_sram_addr, MMIO_BASE};

   assign w_idx   = data_sram_addr[ADDR_W+1:2];
   assign w_wr    = data_sram_en && (data_sram_wen != 4'b0000);
   assign w_rd    = data_sram_en && (data_sram_wen == 4'b0000);
   assign w_wmask = {{8{data_sram_wen[3]}}, {8{data_sram_wen[2]}},
                     {8{data_sram_wen[1]}}, {8{data_sram_wen[0]}}};

`ifdef DSRAM_MMIO_EN
   logic [31:0] r_timer;
   logic [15:0] r_led;
   logic [31:0] r_num;
   logic [15:0] w_off;

   assign w_mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
   assign w_off      = data_sram_addr[15:0];

   // TIMER reads see the pre-increment value of the current edge.
   always_comb begin
      w_mmio_rdata = 32'h0;
      case (w_off)
         16'h0000: w_mmio_rdata = r_timer;
         16'h0004: w_mmio_rdata = {16'h0, r_led};
         16'h0008: w_mmio_rdata = r_num;
         default:  w_mmio_rdata = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_timer <= 32'h0;
         r_led   <= 16'h0;
         r_num   <= 32'h0;
      end else begin
         // A TIMER write replaces the increment for that cycle.
         if (w_wr && w_mmio_hit && (w_off == 16'h0000))
            r_timer <= (r_timer & ~w_wmask) | (data_sram_wdata & w_wmask);
         else
            r_timer <= r_timer + 32'd1;
         if (w_wr && w_mmio_hit && (w_off == 16'h0004))
            r_led <= (r_led & ~w_wmask[15:0]) | (data_sram_wdata[15:0] & w_wmask[15:0]);
         if (w_wr && w_mmio_hit && (w_off == 16'h0008))
            r_num <= (r_num & ~w_wmask) | (data_sram_wdata & w_wmask);
      end
   end

   assign led = r_led;
   assign num = r_num;
`else
   assign w_mmio_hit   = 1'b0;
   assign w_mmio_rdata = 32'h0;
   assign led          = 16'h0;
   assign num          = 32'h0;
`endif

   // RAM has no reset; a request in the reset cycle must not write.
   always_ff @(posedge clk) begin
      if (rst && w_wr && !w_mmio_hit)
         r_mem[w_idx] <= (r_mem[w_idx] & ~w_wmask) | (data_sram_wdata & w_wmask);
   end

   // Reads and writes never coincide on this single port, so the read of a
   // word written in the previous cycle already sees the merged value.
   always_ff @(posedge clk) begin
      if (!rst)
         r_rdata <= 32'h0;
      else if (w_rd)
         r_rdata <= w_mmio_hit ? w_mmio_rdata : r_mem[w_idx];
   end

   assign data_sram_rdata = r_rdata;

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Memory-side responder for the core's data SRAM port: it accepts en/wen/addr/wdata from the core and returns rdata one cycle later, which the MEM stage samples.
- Backs a synchronous word RAM with byte-write merge.
- Decodes an optional MMIO window containing a free-running timer plus LED and NUM output registers.
- Sits at SoC level beside the CPU core, replacing the bare data RAM.

Parameters:
- ADDR_W, 12, word-address bits of the RAM; depth is 2^ADDR_W words (default 16 KB).
- MMIO_BASE, 32'hBFAF_0000, base of the MMIO window; only bits [31:16] are compared.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- data_sram_en  input  1  access request this cycle.
- data_sram_wen  input  4  byte write enables; 4'b0000 with en=1 means read.
- data_sram_addr  input  32  byte address; bits [1:0] ignored.
- data_sram_wdata  input  32  store data, byte-lane aligned.
- data_sram_rdata  output  32  read data, registered, valid the cycle after the read request.
- led  output  16  LED register contents.
- num  output  32  NUM register contents.

Behaviour:
- Reset (rst=0 at a rising edge): data_sram_rdata=0, timer=0, led=0, num=0. RAM contents are not reset.
- A request presented in the reset cycle is discarded: no write, rdata=0 next cycle.
- Decode: MMIO hit when data_sram_addr[31:16]==MMIO_BASE[31:16] and the MMIO feature is compiled in; otherwise RAM.
- RAM index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias (wrap) modulo 2^ADDR_W words.
- Read (en=1, wen=0): data_sram_rdata is loaded at the same edge with the addressed word, so it is visible in the next cycle (latency 1).
- Back-to-back reads sustain one per cycle.
- Write (en=1, wen!=0): each byte lane i with wen[i]=1 is updated with wdata[8i+7:8i]; other lanes are preserved.
- data_sram_rdata holds its previous value on writes and on idle cycles (en=0).
- A read immediately following a write to the same word returns the merged new data (the write commits at the edge; the read samples after it).
- A simultaneous read and write to one word cannot occur (single port).
- MMIO offsets (addr[15:0]):
  - 0x0000 TIMER: RW 32-bit. Increments by 1 every cycle and wraps 0xFFFFFFFF->0.
  - TIMER write: written lanes take wdata and unwritten lanes take the current value; the write wins over the increment in that cycle, and incrementing resumes from the written value next cycle.
  - TIMER read: returns the value before that edge's increment.
  - 0x0004 LED: RW. Only lanes 0 and 1 are stored; reads return {16'b0, led}.
  - 0x0008 NUM: RW 32-bit with byte-lane merge.
  - Any other offset reads 0; writes to it are ignored.
- led and num are driven directly from their registers (0 extra latency after the write edge).
- No stall/ready signalling: the responder always accepts.

Optional Feature:
- Macro DSRAM_MMIO_EN.
- Defined: MMIO decode, TIMER/LED/NUM registers, and led/num outputs are active as described.
- Undefined: all addresses map to RAM (MMIO_BASE is unused), timer logic is absent, and led and num are tied to 0.

Test Plan:
- Write 0x11223344 to 0x0000_0010 with wen=4'hF, then read 0x10 -> rdata=0x11223344 in the cycle after the read request.
- Prior word 0x11223344, then write wen=4'b0101 wdata=0xAABBCCDD, then read -> 0x11BB33DD.
- ADDR_W=12: write 0xDEADBEEF at 0x0000_0000, then read 0x0000_4000 -> 0xDEADBEEF (alias wrap). Reads at 0x4/0x8/0xC back-to-back -> one result per cycle, in order.
- Read followed by idle cycles (en=0) -> rdata holds the value. Assert rst=0 while en=1, wen=0 -> rdata=0 next cycle. Release reset, then read TIMER -> value counts from 0.
- MMIO: write 0xFFFFFFFE to TIMER, read TIMER 3 cycles after the write -> 0x00000001 (wrap). Write LED wdata=0x1234ABCD, wen=4'hF -> led=0xABCD, read -> 0x0000ABCD.
- Build without DSRAM_MMIO_EN: write 0x55 to 0xBFAF_0008 -> led=0, num=0; read 0xBFAF_0008 -> 0x55 from the RAM alias.
